// File: rtl/temp_pkg.sv
// Shared definitions for the temperature LED controller.
// Contents: level encodings, LED bar-graph patterns, the byte layout of the
// RAM temperature word, and a helper that reorders it into a signed value.
package temp_pkg;

    // Classification levels, ordered coldest to hottest
    typedef enum logic [1:0] {
        LVL_COLD   = 2'd0,
        LVL_NORMAL = 2'd1,
        LVL_WARM   = 2'd2,
        LVL_HOT    = 2'd3
    } level_e;

    // Active-low LED patterns (0 = lit)
    localparam logic [3:0] LED_OFF    = 4'b1111;
    localparam logic [3:0] LED_COLD   = 4'b1110;
    localparam logic [3:0] LED_NORMAL = 4'b1100;
    localparam logic [3:0] LED_WARM   = 4'b1000;
    localparam logic [3:0] LED_HOT_ON = 4'b0000;

    localparam int unsigned RAW_W  = 16;
    localparam int unsigned TEMP_W = 8;

    // Temperature word as delivered by the RAM-read stage:
    // upper byte carries RAM 0x55 (low byte), lower byte carries RAM 0x56 (high byte)
    typedef struct packed {
        logic [7:0] lo_byte;
        logic [7:0] hi_byte;
    } temp_word_t;

    // Reassemble the word into a signed value with LSB = 1/256 degC
    function automatic logic signed [RAW_W-1:0] swap_bytes(input temp_word_t word);
        return $signed({word.hi_byte, word.lo_byte});
    endfunction

endpackage

// File: rtl/tick_div.sv
// Free-running cycle divider with hold and synchronous clear.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : advance the counter (holds when low)
//   clr        : synchronous clear to 0 (wins over en)
//   tick_c     : high for the one cycle the counter sits at DIV-1 while enabled
module tick_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // Count 0..DIV-1 and wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign tick_c = en && (cnt == LAST);

endmodule

// File: rtl/temp_led_ctrl.sv
// Temperature LED controller: samples the RAM temperature word, averages the
// last four samples, classifies into four levels with hysteresis and drives a
// four-LED active-low bar graph, blinking all LEDs at the top level.
// Ports:
//   clk_50m  : 50 MHz system clock
//   rst_n    : async active-low reset
//   enable   : 1 = run, 0 = freeze processing and blank LEDs
//   tempture : temperature word, [15:8] = low byte, [7:0] = high byte
//   temp_c   : filtered signed integer degC
//   level    : 0 COLD, 1 NORMAL, 2 WARM, 3 HOT
//   alarm    : high while level is HOT
//   led      : active-low LEDs
module temp_led_ctrl
    import temp_pkg::*;
#(
    parameter int unsigned       SAMPLE_DIV = 50000,
    parameter int unsigned       BLINK_DIV  = 12500000,
    parameter logic signed [7:0] T_COLD     = 8'sd10,
    parameter logic signed [7:0] T_WARM     = 8'sd28,
    parameter logic signed [7:0] T_HOT      = 8'sd35,
    parameter logic [7:0]        HYST       = 8'd2
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] tempture,
    output logic [7:0]  temp_c,
    output logic [1:0]  level,
    output logic        alarm,
    output logic [3:0]  led
);

    localparam int unsigned HIST_N = 4;
    localparam int unsigned SUM_W  = RAW_W + 2;

    localparam logic signed [7:0] TH_COLD_UP = T_COLD + $signed(HYST);
    localparam logic signed [7:0] TH_WARM_DN = T_WARM - $signed(HYST);
    localparam logic signed [7:0] TH_HOT_DN  = T_HOT - $signed(HYST);

    logic                       sample_tick_c;
    logic                       blink_tick_c;
    logic                       blink_run_c;
    logic                       blink_clr_c;
    logic signed [RAW_W-1:0]    raw_c;
    logic signed [SUM_W-1:0]    sum_c;
    logic signed [TEMP_W-1:0]   temp_next_c;

    logic signed [RAW_W-1:0]    hist_q [HIST_N];
    logic                       prime_q;
    logic                       tick_d1_q;
    logic                       tick_d2_q;
    logic signed [TEMP_W-1:0]   temp_q;
    level_e                     level_q;
    logic                       phase_q;
    logic [3:0]                 led_q;
    logic                       alarm_q;

    function automatic logic signed [SUM_W-1:0] ext(input logic signed [RAW_W-1:0] v);
        return $signed({{2{v[RAW_W-1]}}, v});
    endfunction

    // One hysteresis step per evaluation
    function automatic level_e next_level(input level_e cur, input logic signed [7:0] t);
        level_e nxt;
        nxt = cur;
        case (cur)
            LVL_COLD:   if (t >= TH_COLD_UP) nxt = LVL_NORMAL;
            LVL_NORMAL: begin
                if (t < T_COLD)       nxt = LVL_COLD;
                else if (t >= T_WARM) nxt = LVL_WARM;
            end
            LVL_WARM: begin
                if (t < TH_WARM_DN)   nxt = LVL_NORMAL;
                else if (t >= T_HOT)  nxt = LVL_HOT;
            end
            LVL_HOT:    if (t < TH_HOT_DN) nxt = LVL_WARM;
            default:    nxt = cur;
        endcase
        return nxt;
    endfunction

    assign raw_c       = swap_bytes(temp_word_t'(tempture));
    assign sum_c       = ext(hist_q[0]) + ext(hist_q[1]) + ext(hist_q[2]) + ext(hist_q[3]);
    // avg = sum >>> 2, temp = avg[15:8]; both folded into one arithmetic shift
    assign temp_next_c = TEMP_W'(sum_c >>> 10);

    assign blink_run_c = enable && (level_q == LVL_HOT);
    assign blink_clr_c = (level_q != LVL_HOT);

    tick_div #(.DIV(SAMPLE_DIV)) u_sample_div (
        .clk    (clk_50m),
        .rst_n  (rst_n),
        .en     (enable),
        .clr    (1'b0),
        .tick_c (sample_tick_c)
    );

    tick_div #(.DIV(BLINK_DIV)) u_blink_div (
        .clk    (clk_50m),
        .rst_n  (rst_n),
        .en     (blink_run_c),
        .clr    (blink_clr_c),
        .tick_c (blink_tick_c)
    );

    // Sample history: first tick fills all entries, later ticks shift
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_N; i++) hist_q[i] <= '0;
            prime_q <= 1'b0;
        end else if (enable && sample_tick_c) begin
            if (!prime_q) begin
                for (int i = 0; i < HIST_N; i++) hist_q[i] <= raw_c;
                prime_q <= 1'b1;
            end else begin
                hist_q[0] <= raw_c;
                for (int i = 1; i < HIST_N; i++) hist_q[i] <= hist_q[i-1];
            end
        end
    end

    // Filter output one cycle after the tick, level FSM one cycle later
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tick_d1_q <= 1'b0;
            tick_d2_q <= 1'b0;
            temp_q    <= '0;
            level_q   <= LVL_NORMAL;
        end else if (enable) begin
            tick_d1_q <= sample_tick_c;
            tick_d2_q <= tick_d1_q;
            if (tick_d1_q) temp_q  <= temp_next_c;
            if (tick_d2_q) level_q <= next_level(level_q, temp_q);
        end
    end

    // Blink phase; held at 0 outside HOT so entry starts with all LEDs lit
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
        end else if (blink_clr_c) begin
            phase_q <= 1'b0;
        end else if (blink_tick_c) begin
            phase_q <= ~phase_q;
        end
    end

    // LED bar graph and alarm, blanked while disabled
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            led_q   <= LED_OFF;
            alarm_q <= 1'b0;
        end else if (!enable) begin
            led_q   <= LED_OFF;
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= (level_q == LVL_HOT);
            case (level_q)
                LVL_COLD:   led_q <= LED_COLD;
                LVL_NORMAL: led_q <= LED_NORMAL;
                LVL_WARM:   led_q <= LED_WARM;
                LVL_HOT:    led_q <= phase_q ? LED_OFF : LED_HOT_ON;
                default:    led_q <= LED_OFF;
            endcase
        end
    end

    assign temp_c = temp_q;
    assign level  = level_q;
    assign alarm  = alarm_q;
    assign led    = led_q;

endmodule

// File: tb/tb_temp_led_ctrl.sv
// Directed bench for temp_led_ctrl with SAMPLE_DIV = 4 and BLINK_DIV = 8.
// Sample ticks land on every 4th edge after reset release; each table row
// applies a temperature word and checks all outputs once the tick has
// propagated through filter, level FSM and LED stage.
module tb_temp_led_ctrl;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] tempture;
    logic [7:0]  temp_c;
    logic [1:0]  level;
    logic        alarm;
    logic [3:0]  led;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] temp;
        int          cycles;
        logic [7:0]  exp_temp;
        logic [1:0]  exp_level;
        logic        exp_alarm;
        logic [3:0]  exp_led;
    } vec_t;

    vec_t vecs[$];

    temp_led_ctrl #(
        .SAMPLE_DIV (4),
        .BLINK_DIV  (8)
    ) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .enable   (enable),
        .tempture (tempture),
        .temp_c   (temp_c),
        .level    (level),
        .alarm    (alarm),
        .led      (led)
    );

    always #5 clk_50m = ~clk_50m;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] t, input logic [1:0] l,
                             input logic a, input logic [3:0] ld);
        check({tag, "_temp"},  temp_c,           t);
        check({tag, "_level"}, {6'b0, level},    {6'b0, l});
        check({tag, "_alarm"}, {7'b0, alarm},    {7'b0, a});
        check({tag, "_led"},   {4'b0, led},      {4'b0, ld});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    task automatic add_vec(input logic [15:0] tp, input int cyc, input logic [7:0] t,
                           input logic [1:0] l, input logic a, input logic [3:0] ld);
        vec_t v;
        v.temp = tp; v.cycles = cyc; v.exp_temp = t;
        v.exp_level = l; v.exp_alarm = a; v.exp_led = ld;
        vecs.push_back(v);
    endtask

    initial begin
        // prime at 20, ramp to 40 (blink phases), hysteresis down, negatives, extremes
        add_vec(16'h0014, 7, 8'h14, 2'd1, 1'b0, 4'b1100);
        add_vec(16'h0028, 4, 8'h19, 2'd1, 1'b0, 4'b1100);
        add_vec(16'h0028, 4, 8'h1E, 2'd2, 1'b0, 4'b1000);
        add_vec(16'h0028, 4, 8'h23, 2'd3, 1'b1, 4'b0000);
        add_vec(16'h0028, 4, 8'h28, 2'd3, 1'b1, 4'b0000);
        add_vec(16'h0028, 4, 8'h28, 2'd3, 1'b1, 4'b1111);
        add_vec(16'h0022, 4, 8'h26, 2'd3, 1'b1, 4'b1111);
        add_vec(16'h0022, 4, 8'h25, 2'd3, 1'b1, 4'b0000);
        add_vec(16'h0022, 4, 8'h23, 2'd3, 1'b1, 4'b0000);
        add_vec(16'h0022, 4, 8'h22, 2'd3, 1'b1, 4'b1111);
        add_vec(16'h0020, 4, 8'h21, 2'd3, 1'b1, 4'b1111);
        add_vec(16'h0020, 4, 8'h21, 2'd3, 1'b1, 4'b0000);
        add_vec(16'h0020, 4, 8'h20, 2'd2, 1'b0, 4'b1000);
        add_vec(16'h00FB, 4, 8'h16, 2'd1, 1'b0, 4'b1100);
        add_vec(16'h00FB, 4, 8'h0D, 2'd1, 1'b0, 4'b1100);
        add_vec(16'h00FB, 4, 8'h04, 2'd0, 1'b0, 4'b1110);
        add_vec(16'h00FB, 4, 8'hFB, 2'd0, 1'b0, 4'b1110);
        add_vec(16'hFFFF, 4, 8'hFC, 2'd0, 1'b0, 4'b1110);
        add_vec(16'hFFFF, 4, 8'hFD, 2'd0, 1'b0, 4'b1110);
        add_vec(16'hFFFF, 4, 8'hFE, 2'd0, 1'b0, 4'b1110);
        add_vec(16'hFFFF, 4, 8'hFF, 2'd0, 1'b0, 4'b1110);
        add_vec(16'h0000, 4, 8'hFF, 2'd0, 1'b0, 4'b1110);
        add_vec(16'h0000, 4, 8'hFF, 2'd0, 1'b0, 4'b1110);
        add_vec(16'h0000, 4, 8'hFF, 2'd0, 1'b0, 4'b1110);
        add_vec(16'h0000, 4, 8'h00, 2'd0, 1'b0, 4'b1110);
        add_vec(16'h0080, 4, 8'hE0, 2'd0, 1'b0, 4'b1110);
        add_vec(16'h0080, 4, 8'hC0, 2'd0, 1'b0, 4'b1110);
        add_vec(16'h0080, 4, 8'hA0, 2'd0, 1'b0, 4'b1110);
        add_vec(16'h0080, 4, 8'h80, 2'd0, 1'b0, 4'b1110);

        rst_n    = 1'b0;
        enable   = 1'b1;
        tempture = 16'h0014;
        step(3);
        check_all("reset", 8'h00, 2'd1, 1'b0, 4'b1111);
        @(posedge clk_50m);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            tempture = vecs[i].temp;
            enable   = 1'b1;
            step(vecs[i].cycles);
            check_all($sformatf("v%0d", i), vecs[i].exp_temp, vecs[i].exp_level,
                      vecs[i].exp_alarm, vecs[i].exp_led);
        end

        // Freeze for 20 cycles with the sample counter parked at its last count
        enable   = 1'b0;
        tempture = 16'h0028;
        step(1);
        check_all("frz_a", 8'h80, 2'd0, 1'b0, 4'b1111);
        step(9);
        tempture = 16'h00FB;
        step(10);
        check_all("frz_b", 8'h80, 2'd0, 1'b0, 4'b1111);

        // Resume: held count ticks at once, history shifts without re-prime
        enable   = 1'b1;
        tempture = 16'h0014;
        step(1);
        check_all("reen", 8'h80, 2'd0, 1'b0, 4'b1110);
        step(1);
        check("reen_avg", temp_c, 8'hA5);

        // Asynchronous reset between edges clears everything
        rst_n = 1'b0;
        #1;
        check_all("arst_a", 8'h00, 2'd1, 1'b0, 4'b1111);

        // Fresh run at 40 with a short glitch between ticks, up to HOT
        tempture = 16'h0028;
        step(2);
        rst_n = 1'b1;
        step(1);
        tempture = 16'h0000;
        step(1);
        tempture = 16'h0028;
        step(3);
        check_all("hot_a", 8'h28, 2'd1, 1'b0, 4'b1100);
        step(2);
        check_all("hot_b", 8'h28, 2'd2, 1'b0, 4'b1000);
        step(4);
        check_all("hot_c", 8'h28, 2'd3, 1'b1, 4'b0000);

        // Reset mid-HOT, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_all("arst_hot", 8'h00, 2'd1, 1'b0, 4'b1111);
        step(2);
        check_all("arst_hold", 8'h00, 2'd1, 1'b0, 4'b1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/temp_led_ctrl.md
Name: temp_led_ctrl

Overview:
- Downstream consumer of the 16-bit temperature word produced by the RAM-read stage; sits in place of the LED driver.
- Samples the temperature word periodically and averages the last four samples.
- Classifies the averaged value into four levels with hysteresis and drives four active-low board LEDs as a bar graph, with a blinking alarm at the top level.

Parameters:
- SAMPLE_DIV, 50000: clk_50m cycles per sample tick (1 ms at 50 MHz).
- BLINK_DIV, 12500000: clk_50m cycles per alarm blink toggle (2 Hz blink).
- T_COLD, 8'sd10: signed integer °C, lower threshold.
- T_WARM, 8'sd28: signed integer °C, warm threshold.
- T_HOT, 8'sd35: signed integer °C, hot threshold.
- HYST, 8'd2: hysteresis band in integer °C.

Ports:
- clk_50m  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  1 = run; 0 = freeze processing and blank LEDs
- tempture  input  16  from RAM-read stage: [15:8] = low byte (RAM 0x55), [7:0] = high byte (RAM 0x56)
- temp_c  output  8  signed filtered integer °C
- level  output  2  0 = COLD, 1 = NORMAL, 2 = WARM, 3 = HOT
- alarm  output  1  high while level == HOT
- led  output  4  active-low LEDs (0 = lit)

Behaviour:
- Reset (async, rst_n low) values:
  - led = 4'b1111, temp_c = 0, level = NORMAL, alarm = 0.
  - All counters = 0, history = 0, prime flag = 0, blink phase = 0.
- Byte swap: raw = {tempture[7:0], tempture[15:8]}, signed, LSB = 1/256 °C.
- Sample tick:
  - sample_cnt counts 0..SAMPLE_DIV-1 while enable = 1, then wraps.
  - The tick fires on the cycle sample_cnt == SAMPLE_DIV-1.
- History update on each tick:
  - First tick after reset (prime = 0): all 4 entries are loaded with raw, and prime is set.
  - Later ticks: shift raw in, drop the oldest entry.
- Averaging:
  - Sum of the 4 entries is 18-bit signed.
  - avg = sum >>> 2 (arithmetic shift, truncate toward -inf).
  - temp_c = avg[15:8], registered one cycle after the tick.
- Level FSM: evaluated on the cycle after temp_c updates (2 cycles after the tick). Moves at most one step per evaluation.
  - COLD -> NORMAL: temp_c >= T_COLD+HYST
  - NORMAL -> COLD: temp_c < T_COLD
  - NORMAL -> WARM: temp_c >= T_WARM
  - WARM -> NORMAL: temp_c < T_WARM-HYST
  - WARM -> HOT: temp_c >= T_HOT
  - HOT -> WARM: temp_c < T_HOT-HYST
  - Otherwise hold the current level.
  - All comparisons are signed 8-bit.
  - Going from COLD to HOT therefore takes 3 evaluations.
- Blink:
  - blink_cnt runs only while level == HOT.
  - Blink phase toggles at BLINK_DIV-1.
  - Counter and phase clear to 0 on leaving HOT.
- LED mapping (registered, 1 cycle after level changes):
  - COLD = 4'b1110
  - NORMAL = 4'b1100
  - WARM = 4'b1000
  - HOT = phase ? 4'b1111 : 4'b0000 (all LEDs lit immediately on entering HOT)
- alarm = (level == HOT), registered alongside led.
- enable = 0:
  - sample_cnt, blink_cnt, history, temp_c and level all hold.
  - led forced to 4'b1111, alarm forced to 0.
  - On re-enable, counting resumes from the held values with no re-prime.
- Boundaries:
  - tempture = 16'h0000 (0 °C) and 16'hFFFF (raw 0xFFFF = -1/256 °C, temp_c = -1) are legal.
  - Extreme inputs (e.g. raw 0x8000) must not overflow: the sum is 18-bit.
  - A tempture change between ticks is ignored; only the value present at the tick is sampled.
  - rst_n asserted mid-operation returns every output to its reset value asynchronously.

Decomposition:
- Shared package temp_pkg:
  - level encodings LVL_COLD/NORMAL/WARM/HOT.
  - LED patterns for each level.
  - Byte-order constants for the RAM temperature word.
- One natural sub-module: tick_div (parameterised cycle counter with enable, one-cycle tick output). It is instantiated twice, for the sample tick and the blink tick.

Test Plan (bench uses SAMPLE_DIV = 4, BLINK_DIV = 8):
1. Reset: hold rst_n low, then release with enable = 1 and tempture = 16'h0014 (20 °C) -> outputs at reset values during reset; after the first tick, temp_c = 20, level = NORMAL, led = 4'b1100.
2. Ramp: step tempture 16'h0014 -> 16'h0028 (40 °C) -> temp_c converges to 40 over 4 ticks; level moves NORMAL -> WARM -> HOT (one step per evaluation); HOT led alternates 4'b0000 / 4'b1111 every 8 cycles; alarm = 1.
3. Hysteresis: from HOT, set tempture = 16'h0022 (34 °C) -> level stays HOT; set 16'h0020 (32 °C) -> level = WARM, alarm = 0, led = 4'b1000.
4. Negative: tempture = 16'h00FB (raw 0xFB00 = -5 °C) after priming -> temp_c = 8'hFB; level reaches COLD; led = 4'b1110.
5. Enable freeze: drop enable for 20 cycles while tempture changes -> led = 4'b1111, alarm = 0, temp_c unchanged; on re-enable, the previous level pattern returns.
6. Async reset mid-HOT: assert rst_n between clock edges -> led = 4'b1111 and level = NORMAL immediately, with no clock edge needed.
